// File: rtl/deco_7seg_barrido.sv
// deco_7seg_barrido: time-multiplexed scanner for a 4-digit common-anode
// 7-segment display. Once per frame it takes a coherent snapshot of the four
// digit codes. It then steps through the digits with a programmable slot
// length and drives registered anode, segment and decimal-point levels.
// Every slot starts with one guard cycle (all anodes off) so that the segment
// change never shows up on the previous digit.
// Optional feature: define DECO_7SEG_LZB_EN to blank a leading zero on digit 3.
module deco_7seg_barrido #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] n_0f,
    input  logic [3:0] n_1f,
    input  logic [3:0] n_2f,
    input  logic [3:0] n_3f,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int             CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0]  CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [3:0]     CODE_DP    = 4'd10;
    localparam logic [3:0]     CODE_BLANK = 4'd11;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic                first_q;
    logic [3:0][3:0]     snap_q, snap_d;
    logic [3:0]          an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                ft_q, ft_d;

    logic                wrap;
    logic [3:0]          code;
    logic                blank_lz;

    // Slot counter, digit index and snapshot control.
    always_comb begin
        wrap   = (cnt_q == CNT_MAX);
        cnt_d  = wrap ? '0 : cnt_q + CW'(1);
        idx_d  = wrap ? idx_q + 2'd1 : idx_q;
        snap_d = snap_q;
        // Take the snapshot at the end of the frame. The very first cycle after
        // reset also loads it, so that the first frame is not entirely blank.
        if ((wrap && (idx_q == 2'd3)) || first_q) begin
            snap_d = {n_3f, n_2f, n_1f, n_0f};
        end
    end

    // Code-to-segment decode and anode/tick generation feeding the output stage.
    always_comb begin
        code = snap_q[idx_q];
`ifdef DECO_7SEG_LZB_EN
        blank_lz = (idx_q == 2'd3) && (snap_q[3] == 4'd0) && (snap_q[2] != CODE_DP);
`else
        blank_lz = 1'b0;
`endif
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (!blank_lz) begin
            case (code)
                4'd0:    seg_d = 7'h40;
                4'd1:    seg_d = 7'h79;
                4'd2:    seg_d = 7'h24;
                4'd3:    seg_d = 7'h30;
                4'd4:    seg_d = 7'h19;
                4'd5:    seg_d = 7'h12;
                4'd6:    seg_d = 7'h02;
                4'd7:    seg_d = 7'h78;
                4'd8:    seg_d = 7'h00;
                4'd9:    seg_d = 7'h10;
                default: seg_d = 7'h7F;
            endcase
            dp_d = (code != CODE_DP);
        end
        // Guard cycle: anodes stay off while segments settle on the new digit.
        an_d = (cnt_q == '0) ? 4'hF : ~(4'(1) << idx_q);
        ft_d = (cnt_q == '0) && (idx_q == 2'd0);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= 2'd0;
            first_q <= 1'b1;
            snap_q  <= {4{CODE_BLANK}};
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            ft_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            ft_q    <= ft_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = ft_q;

endmodule

// File: tb/tb_deco_7seg_barrido.sv
module tb_deco_7seg_barrido;

    localparam int DIV = 4;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] n_0f, n_1f, n_2f, n_3f;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on  = 1'b0;
    bit   chk_tgl = 1'b0;
    bit   tmo_tgl = 1'b0;
    event chk_ev;

    // digit codes per vector: {n3, n2, n1, n0}
    logic [3:0] vec [5][4];

    deco_7seg_barrido #(.REFRESH_DIV(DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .n_0f       (n_0f),
        .n_1f       (n_1f),
        .n_2f       (n_2f),
        .n_3f       (n_3f),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        case (c)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    // Expected output stream for one frame; 'first' marks the frame right after
    // reset, whose digit-0 guard cycle still shows the blank reset snapshot.
    task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0,
                              input bit first);
        logic [3:0] codes [4];
        logic [6:0] s;
        logic       p;
        obs_t       e;
        codes[0] = d0; codes[1] = d1; codes[2] = d2; codes[3] = d3;
        for (int d = 0; d < 4; d++) begin
            s = seg_of(codes[d]);
            p = (codes[d] != 4'd10);
`ifdef DECO_7SEG_LZB_EN
            if (d == 3 && d3 == 4'd0 && d2 != 4'd10) begin
                s = 7'h7F;
                p = 1'b1;
            end
`endif
            e.an  = 4'hF;
            e.seg = (first && d == 0) ? 7'h7F : s;
            e.dp  = (first && d == 0) ? 1'b1  : p;
            e.ft  = (d == 0);
            exp_q.push_back(e);
            for (int k = 1; k < DIV; k++) begin
                e.an  = ~(4'(1) << d);
                e.seg = s;
                e.dp  = p;
                e.ft  = 1'b0;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic check_reset_now();
        obs_t e;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.ft = 1'b0;
        exp_q.push_back(e);
        chk_tgl = ~chk_tgl;
        ->chk_ev;
    endtask

    task automatic flag_timeout();
        tmo_tgl = ~tmo_tgl;
        ->chk_ev;
    endtask

    task automatic set_inputs(input int j);
        n_3f = vec[j][0]; n_2f = vec[j][1]; n_1f = vec[j][2]; n_0f = vec[j][3];
    endtask

    // Monitor: pops one expected entry per sampled output cycle or on request.
    initial begin
        bit   chk_seen = 1'b0;
        bit   tmo_seen = 1'b0;
        obs_t e, g;
        forever begin
            @(negedge clk or chk_ev);
            if (tmo_tgl != tmo_seen) begin
                tmo_seen = tmo_tgl;
                total++;
                bad++;
                $display("FAIL wait_bound got=expired want=event_seen t=%0t", $time);
            end else if (mon_on || (chk_tgl != chk_seen)) begin
                chk_seen = chk_tgl;
                total++;
                g = '{an: an, seg: seg, dp: dp, ft: frame_tick};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard_empty got an=%b seg=%h dp=%b ft=%b want=none t=%0t",
                             an, seg, dp, frame_tick, $time);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        bad++;
                        $display("FAIL scan_out got an=%b seg=%h dp=%b ft=%b want an=%b seg=%h dp=%b ft=%b t=%0t",
                                 g.an, g.seg, g.dp, g.ft, e.an, e.seg, e.dp, e.ft, $time);
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        int  ec;
        bit  found;
        vec[0] = '{4'd0,  4'd10, 4'd3,  4'd9};
        vec[1] = '{4'd0,  4'd10, 4'd3,  4'd8};
        vec[2] = '{4'd15, 4'd14, 4'd13, 4'd12};
        vec[3] = '{4'd0,  4'd1,  4'd2,  4'd5};
        vec[4] = '{4'd0,  4'd10, 4'd5,  4'd0};

        rst_n = 1'b0;
        set_inputs(0);
        repeat (3) @(negedge clk);
        #1 check_reset_now();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_now();

        // Frames 1 and 2 show vec0; vec j set after edge 16j+4 shows in frame j+2.
        push_frame(vec[0][0], vec[0][1], vec[0][2], vec[0][3], 1'b1);
        push_frame(vec[0][0], vec[0][1], vec[0][2], vec[0][3], 1'b0);
        @(posedge clk);
        ec = 1;
        #1 mon_on = 1'b1;
        for (int j = 1; j < 5; j++) begin
            repeat (16 * j + 4 - ec) @(posedge clk);
            ec = 16 * j + 4;
            @(negedge clk);
            set_inputs(j);
            push_frame(vec[j][0], vec[j][1], vec[j][2], vec[j][3], 1'b0);
        end
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        mon_on = 1'b0;
        if (exp_q.size() != 0) begin
            flag_timeout();
            exp_q.delete();
        end

        // Reset in the middle of the digit 2 slot.
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == 4'b1011) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) flag_timeout();
        #2 rst_n = 1'b0;
        #1 check_reset_now();
        repeat (3) @(posedge clk);
        #1 check_reset_now();
        @(negedge clk);
        rst_n = 1'b1;
        #1 check_reset_now();
        push_frame(vec[4][0], vec[4][1], vec[4][2], vec[4][3], 1'b1);
        push_frame(vec[4][0], vec[4][1], vec[4][2], vec[4][3], 1'b0);
        @(posedge clk);
        #1 mon_on = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        mon_on = 1'b0;
        if (exp_q.size() != 0) begin
            flag_timeout();
            exp_q.delete();
        end

        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deco_7seg_barrido.md
# deco_7seg_barrido

Time-multiplexed scanner that drives a 4-digit common-anode 7-segment display from four 4-bit digit codes, as produced by the frequency digit decoder. The block takes a coherent snapshot of the four codes once per frame, cycles through the digits with a programmable slot length, and converts each code to segment and decimal-point levels. It sits between the digit-code sources and the board display pins.

## Interface
- REFRESH_DIV, default 100000: clock cycles per digit slot; legal range 2..2^20.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset; release is synchronised externally.
- n_0f  input  4  digit code, rightmost digit (digit 0).
- n_1f  input  4  digit code, digit 1.
- n_2f  input  4  digit code, digit 2.
- n_3f  input  4  digit code, leftmost digit (digit 3).
- an  output  4  anode enables, active low, an[k] selects digit k.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_tick  output  1  one-cycle pulse at the start of each frame (digit 0 slot).

## Operation
- Slot counter `cnt` runs 0..REFRESH_DIV-1 and wraps. On wrap, the digit index `idx` (2 bits) advances 0→1→2→3→0.
- Snapshot: in the cycle where `cnt` wraps with `idx`=3, all four inputs are registered together into `snap[3:0]`. Input changes at any other time have no effect until the next frame. The first snapshot after reset is taken in the first cycle after reset release (cnt=0, idx=0).
- Code to segment mapping (seg hex, active low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10; dp=1 for 0..9.
- Code 10: decimal-point glyph, seg=7F, dp=0.
- Codes 11..15: blank, seg=7F, dp=1.
- Ghost guard: in slot cycle cnt=0, an=1111 while seg/dp switch to the new digit. For cnt≥1, an[idx]=0 and the other anodes are 1.
- frame_tick=1 exactly during the cnt=0, idx=0 cycle.
- All outputs are registered. There is no combinational path from the inputs to the outputs.

## Timing
- Reset values (asynchronous): cnt=0, idx=0, snap=all 11 (blank), an=1111, seg=7F, dp=1, frame_tick=0.
- Frame length is 4×REFRESH_DIV cycles. Each digit is lit for REFRESH_DIV−1 cycles per frame.
- Latency: an input change that is stable before the snapshot edge first appears on seg/dp in the following cnt=0, idx=0 cycle. That is one cycle after the snapshot edge, because the snapshot and the output registers are pipelined by one stage.
- Because of the output pipeline, registered `an`, `seg`, `dp` and `frame_tick` trail the internal cnt/idx by one cycle. The relationships above hold between the outputs themselves.
- Reset asserted mid-frame forces the reset values immediately. After release, scanning restarts from digit 0 with guard cycle first.
- REFRESH_DIV=2 is legal: each slot has one guard cycle and one lit cycle.

## Configuration
- DECO_7SEG_LZB_EN defined: leading-zero blanking on digit 3. If snap[3]=0 and snap[2]≠10, digit 3 shows seg=7F, dp=1. The digit 3 anode still follows the normal scan.
- DECO_7SEG_LZB_EN undefined: digit 3 uses the normal mapping, so code 0 shows "0".

## Test plan
- Reset with REFRESH_DIV=4 → an=1111, seg=7F, dp=1, frame_tick=0 during reset and through the first output cycle after release.
- Codes n3..n0 = 0,10,3,9 → per frame, after one warm-up frame: digit 0 seg=10, digit 1 seg=30, digit 2 seg=7F with dp=0, digit 3 seg=40. Each digit has an low for 3 cycles and 1111 in its guard cycle.
- Change n_0f from 9 to 8 mid-frame → digit 0 keeps 10 until the next frame, then shows 00. Other digits are unchanged.
- Codes 15,14,13,12 → all slots seg=7F, dp=1. frame_tick pulses every 16 cycles.
- With DECO_7SEG_LZB_EN, codes 0,1,2,5 → digit 3 blank. With codes 0,10,5,0 → digit 3 shows 40. Without the macro, both cases show 40 on digit 3.
- Assert rst_n low during the digit 2 slot, release after 3 cycles → outputs return to reset values asynchronously. The next lit digit is digit 0, after one guard cycle.
